vend_session_arbiter: RTL and testbench

Shares one `vending_mach` core between two customer front panels, panel 0 and panel 1.
- Grants the core to one panel per session.
- Forwards only the owner's coin, select and cancel pulses, as registered single-cycle pulses.
- Returns the sale result (done, change) to the owner.
- Cancels abandoned sessions after an inactivity timeout.

Sits between the panel debouncers and the core's `Fiverupee/Tenrupee/Lemonwater/Sodabottle/Waterbottle/cancel` inputs.

---
 rtl/vend_pkg.sv | 21 ++
 rtl/vend_idle_timer.sv | 31 +++
 rtl/vend_session_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_vend_session_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending session arbiter.
package vend_pkg;

  // Change value width returned by the vending core.
  localparam int COIN_W = 5;

  // Product codes carried on the panel select buses.
  localparam logic [1:0] PROD_NONE  = 2'd0;
  localparam logic [1:0] PROD_LEMON = 2'd1;
  localparam logic [1:0] PROD_SODA  = 2'd2;
  localparam logic [1:0] PROD_WATER = 2'd3;

  // Session state machine.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    CANCEL = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/vend_idle_timer.sv
// Saturating inactivity counter; expired is high once the count reaches
// TIMEOUT_CYCLES-1.
module vend_idle_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Count enabled cycles, clear on request, hold at the terminal value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != LAST)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = (r_count == LAST);

endmodule

// File: rtl/vend_session_arbiter.sv
// Shares one vending core between two panels: round-robin session grant,
// owner-only input forwarding, result return and inactivity cancel.
module vend_session_arbiter
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_Fiverupee,
  input  logic              p0_Tenrupee,
  input  logic [1:0]        p0_sel,
  input  logic              p0_cancel,
  input  logic              p1_req,
  input  logic              p1_Fiverupee,
  input  logic              p1_Tenrupee,
  input  logic [1:0]        p1_sel,
  input  logic              p1_cancel,
  input  logic              give,
  input  logic [COIN_W-1:0] change,
  output logic              Fiverupee,
  output logic              Tenrupee,
  output logic              Lemonwater,
  output logic              Sodabottle,
  output logic              Waterbottle,
  output logic              cancel,
  output logic              p0_grant,
  output logic              p1_grant,
  output logic              p0_done,
  output logic              p1_done,
  output logic [COIN_W-1:0] p0_change,
  output logic [COIN_W-1:0] p1_change,
  output logic              p0_timeout,
  output logic              p1_timeout,
  output logic              err_spurious_give
);

  state_e r_state, w_state_next;
  logic   r_owner, w_owner_next;
  logic   r_last_owner, w_last_owner_next;

  logic r_five, r_ten, r_lemon, r_soda, r_water, r_cancel, r_err;
  logic w_five_next, w_ten_next, w_lemon_next, w_soda_next, w_water_next;
  logic w_cancel_next, w_err_next;
  logic [1:0] r_grant, w_grant_next;
  logic [1:0] r_done, w_done_next;
  logic [1:0] r_timeout, w_timeout_next;
  logic [1:0][COIN_W-1:0] r_change, w_change_next;

  logic       w_pick, w_timer_clr, w_timer_en, w_expired, w_fwd;
  logic       w_own_five, w_own_ten, w_own_cancel;
  logic [1:0] w_own_sel;

  // Tie goes to the panel that did not own the previous session.
  assign w_pick = (p0_req && p1_req) ? ~r_last_owner : p1_req;

  // Owner input mux; the other panel never reaches the core.
  assign w_own_five   = r_owner ? p1_Fiverupee : p0_Fiverupee;
  assign w_own_ten    = r_owner ? p1_Tenrupee  : p0_Tenrupee;
  assign w_own_sel    = r_owner ? p1_sel       : p0_sel;
  assign w_own_cancel = r_owner ? p1_cancel    : p0_cancel;

  assign w_timer_en = (r_state == ACTIVE);

  // A cancel that is not pre-empted by give swallows same-cycle coin/select.
  assign w_fwd = (r_state == ACTIVE) && !(w_own_cancel && !give);

  vend_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_timer_clr),
    .en     (w_timer_en),
    .expired(w_expired)
  );

  // Next-state and next-output logic for the session FSM.
  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_last_owner_next = r_last_owner;
    w_five_next       = 1'b0;
    w_ten_next        = 1'b0;
    w_lemon_next      = 1'b0;
    w_soda_next       = 1'b0;
    w_water_next      = 1'b0;
    w_cancel_next     = 1'b0;
    w_grant_next      = 2'b00;
    w_done_next       = 2'b00;
    w_timeout_next    = 2'b00;
    w_change_next     = r_change;
    w_timer_clr       = 1'b0;
    w_err_next        = give && (r_state != ACTIVE);

    if (w_fwd) begin
      w_ten_next   = w_own_ten;
      w_five_next  = w_own_five && !w_own_ten;
      w_lemon_next = (w_own_sel == PROD_LEMON);
      w_soda_next  = (w_own_sel == PROD_SODA);
      w_water_next = (w_own_sel == PROD_WATER);
      w_timer_clr  = w_own_five || w_own_ten || (w_own_sel != PROD_NONE);
    end

    case (r_state)
      IDLE: begin
        if (p0_req || p1_req) begin
          w_state_next             = ACTIVE;
          w_owner_next             = w_pick;
          w_last_owner_next        = w_pick;
          w_timer_clr              = 1'b1;
          w_change_next[w_pick]    = '0;
        end
      end
      ACTIVE: begin
        if (give) begin
          w_state_next           = DONE;
          w_change_next[r_owner] = change;
        end else if (w_own_cancel) begin
          w_cancel_next = 1'b1;
          w_state_next  = CANCEL;
        end else if (w_expired) begin
          w_cancel_next           = 1'b1;
          w_timeout_next[r_owner] = 1'b1;
          w_state_next            = CANCEL;
        end
      end
      CANCEL: begin
        w_change_next[r_owner] = change;
        w_state_next           = DONE;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    w_grant_next[w_owner_next] = (w_state_next == ACTIVE) || (w_state_next == CANCEL);
    w_done_next[w_owner_next]  = (w_state_next == DONE);
  end

  // State, ownership and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_five       <= 1'b0;
      r_ten        <= 1'b0;
      r_lemon      <= 1'b0;
      r_soda       <= 1'b0;
      r_water      <= 1'b0;
      r_cancel     <= 1'b0;
      r_err        <= 1'b0;
      r_grant      <= 2'b00;
      r_done       <= 2'b00;
      r_timeout    <= 2'b00;
      r_change     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_last_owner <= w_last_owner_next;
      r_five       <= w_five_next;
      r_ten        <= w_ten_next;
      r_lemon      <= w_lemon_next;
      r_soda       <= w_soda_next;
      r_water      <= w_water_next;
      r_cancel     <= w_cancel_next;
      r_err        <= w_err_next;
      r_grant      <= w_grant_next;
      r_done       <= w_done_next;
      r_timeout    <= w_timeout_next;
      r_change     <= w_change_next;
    end
  end

  assign Fiverupee         = r_five;
  assign Tenrupee          = r_ten;
  assign Lemonwater        = r_lemon;
  assign Sodabottle        = r_soda;
  assign Waterbottle       = r_water;
  assign cancel            = r_cancel;
  assign p0_grant          = r_grant[0];
  assign p1_grant          = r_grant[1];
  assign p0_done           = r_done[0];
  assign p1_done           = r_done[1];
  assign p0_change         = r_change[0];
  assign p1_change         = r_change[1];
  assign p0_timeout        = r_timeout[0];
  assign p1_timeout        = r_timeout[1];
  assign err_spurious_give = r_err;

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Directed self-checking bench for vend_session_arbiter (TIMEOUT_CYCLES = 8).
module tb_vend_session_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       p0_req = 0, p0_Fiverupee = 0, p0_Tenrupee = 0, p0_cancel = 0;
  logic       p1_req = 0, p1_Fiverupee = 0, p1_Tenrupee = 0, p1_cancel = 0;
  logic [1:0] p0_sel = 0, p1_sel = 0;
  logic       give = 0;
  logic [4:0] change = 0;
  logic       Fiverupee, Tenrupee, Lemonwater, Sodabottle, Waterbottle, cancel;
  logic       p0_grant, p1_grant, p0_done, p1_done, p0_timeout, p1_timeout;
  logic [4:0] p0_change, p1_change;
  logic       err_spurious_give;

  int n_pass = 0;
  int n_total = 0;

  // core = {Fiverupee, Tenrupee, Lemonwater, Sodabottle, Waterbottle, cancel}
  logic [5:0]  core;
  logic [1:0]  grants;   // {p0_grant, p1_grant}
  logic [22:0] all_out;
  assign core    = {Fiverupee, Tenrupee, Lemonwater, Sodabottle, Waterbottle, cancel};
  assign grants  = {p0_grant, p1_grant};
  assign all_out = {core, p0_grant, p1_grant, p0_done, p1_done, p0_change, p1_change,
                    p0_timeout, p1_timeout, err_spurious_give};

  vend_session_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_Fiverupee(p0_Fiverupee), .p0_Tenrupee(p0_Tenrupee),
    .p0_sel(p0_sel), .p0_cancel(p0_cancel),
    .p1_req(p1_req), .p1_Fiverupee(p1_Fiverupee), .p1_Tenrupee(p1_Tenrupee),
    .p1_sel(p1_sel), .p1_cancel(p1_cancel),
    .give(give), .change(change),
    .Fiverupee(Fiverupee), .Tenrupee(Tenrupee), .Lemonwater(Lemonwater),
    .Sodabottle(Sodabottle), .Waterbottle(Waterbottle), .cancel(cancel),
    .p0_grant(p0_grant), .p1_grant(p1_grant), .p0_done(p0_done), .p1_done(p1_done),
    .p0_change(p0_change), .p1_change(p1_change),
    .p0_timeout(p0_timeout), .p1_timeout(p1_timeout),
    .err_spurious_give(err_spurious_give)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    p0_req = 0; p0_Fiverupee = 0; p0_Tenrupee = 0; p0_sel = 0; p0_cancel = 0;
    p1_req = 0; p1_Fiverupee = 0; p1_Tenrupee = 0; p1_sel = 0; p1_cancel = 0;
    give = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    p0_req = 1; give = 1; change = 5'd17;
    reset = 1;
    tick();
    tick();
    n_total++;
    if (all_out !== 23'd0) $display("FAIL reset_outputs got=%h exp=%h", all_out, 23'd0);
    else n_pass++;
    reset = 0;
    clear_inputs();
    tick();
    n_total++;
    if (all_out !== 23'd0) $display("FAIL reset_no_leak got=%h exp=%h", all_out, 23'd0);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_single_sale();
    p0_req = 1;
    tick();
    n_total++;
    if ({grants, core} !== 8'b10_000000) $display("FAIL sale_grant got=%b exp=%b", {grants, core}, 8'b10_000000);
    else n_pass++;
    p0_req = 0;
    tick();
    p0_sel = 2'd3;
    tick();
    n_total++;
    if (core !== 6'b000010) $display("FAIL sale_water got=%b exp=%b", core, 6'b000010);
    else n_pass++;
    p0_sel = 0; p0_Tenrupee = 1;
    tick();
    n_total++;
    if (core !== 6'b010000) $display("FAIL sale_ten got=%b exp=%b", core, 6'b010000);
    else n_pass++;
    p0_Tenrupee = 0; give = 1; change = 5'd0;
    tick();
    n_total++;
    if ({p0_done, p0_grant, core, p0_change} !== 13'b1_0_000000_00000)
      $display("FAIL sale_done got=%b exp=%b", {p0_done, p0_grant, core, p0_change}, 13'b1_0_000000_00000);
    else n_pass++;
    give = 0;
    tick();
    n_total++;
    if ({p0_done, err_spurious_give} !== 2'b00) $display("FAIL sale_after_done got=%b exp=%b", {p0_done, err_spurious_give}, 2'b00);
    else n_pass++;
    $display("test_single_sale done");
  endtask

  task automatic test_coin_priority();
    p0_req = 1;
    tick();
    p0_req = 0;
    p0_Fiverupee = 1; p0_Tenrupee = 1; p0_sel = 2'd1;
    tick();
    n_total++;
    if (core !== 6'b011000) $display("FAIL coin_both got=%b exp=%b", core, 6'b011000);
    else n_pass++;
    p0_Tenrupee = 0; p0_sel = 2'd2;
    tick();
    n_total++;
    if (core !== 6'b100100) $display("FAIL coin_five_soda got=%b exp=%b", core, 6'b100100);
    else n_pass++;
    clear_inputs();
    give = 1; change = 5'd7;
    tick();
    n_total++;
    if ({p0_done, p0_change} !== {1'b1, 5'd7}) $display("FAIL coin_change got=%b exp=%b", {p0_done, p0_change}, {1'b1, 5'd7});
    else n_pass++;
    give = 0;
    tick();
    $display("test_coin_priority done");
  endtask

  task automatic test_isolation();
    p0_req = 1;
    tick();
    p0_req = 0;
    p1_req = 1; p1_Fiverupee = 1; p1_Tenrupee = 1; p1_sel = 2'd2; p1_cancel = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({grants, core} !== 8'b10_000000) $display("FAIL isolation_%0d got=%b exp=%b", i, {grants, core}, 8'b10_000000);
      else n_pass++;
    end
    clear_inputs();
    p0_cancel = 1; p0_Fiverupee = 1; change = 5'd3;
    tick();
    n_total++;
    if ({core, p0_timeout} !== 7'b000001_0) $display("FAIL cancel_suppress got=%b exp=%b", {core, p0_timeout}, 7'b000001_0);
    else n_pass++;
    clear_inputs();
    tick();
    n_total++;
    if ({p0_done, core, p0_change} !== {1'b1, 6'b0, 5'd3}) $display("FAIL cancel_done got=%b exp=%b", {p0_done, core, p0_change}, {1'b1, 6'b0, 5'd3});
    else n_pass++;
    tick();
    $display("test_isolation done");
  endtask

  task automatic test_collision();
    p0_req = 1;
    tick();
    p0_req = 0;
    p0_cancel = 1; give = 1; change = 5'd5;
    tick();
    n_total++;
    if ({core, p0_done, p0_change} !== {6'b0, 1'b1, 5'd5}) $display("FAIL collision got=%b exp=%b", {core, p0_done, p0_change}, {6'b0, 1'b1, 5'd5});
    else n_pass++;
    clear_inputs();
    tick();
    $display("test_collision done");
  endtask

  task automatic test_spurious_give();
    give = 1;
    tick();
    n_total++;
    if ({err_spurious_give, grants} !== 3'b100) $display("FAIL spurious_give got=%b exp=%b", {err_spurious_give, grants}, 3'b100);
    else n_pass++;
    give = 0;
    tick();
    n_total++;
    if (err_spurious_give !== 1'b0) $display("FAIL spurious_clear got=%b exp=%b", err_spurious_give, 1'b0);
    else n_pass++;
    $display("test_spurious_give done");
  endtask

  task automatic test_timeout();
    // Plain timeout: cancel exactly 8 cycles after the grant.
    p0_req = 1;
    tick();
    p0_req = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_total++;
      if ({cancel, p0_timeout} !== ((k == 8) ? 2'b11 : 2'b00))
        $display("FAIL timeout_g+%0d got=%b exp=%b", k, {cancel, p0_timeout}, ((k == 8) ? 2'b11 : 2'b00));
      else n_pass++;
    end
    tick();
    n_total++;
    if ({p0_done, p0_timeout, cancel} !== 3'b100) $display("FAIL timeout_done got=%b exp=%b", {p0_done, p0_timeout, cancel}, 3'b100);
    else n_pass++;
    tick();
    // Coin at grant+5 restarts the count: cancel at grant+14.
    p0_req = 1;
    tick();
    p0_req = 0;
    for (int p = 0; p < 14; p++) begin
      p0_Fiverupee = (p == 5);
      tick();
      if ((p + 1 == 6) || (p + 1 >= 13)) begin
        n_total++;
        if ({Fiverupee, cancel, p0_timeout} !== {(p + 1 == 6), (p + 1 == 14), (p + 1 == 14)})
          $display("FAIL timeout_push_g+%0d got=%b exp=%b", p + 1, {Fiverupee, cancel, p0_timeout},
                   {(p + 1 == 6), (p + 1 == 14), (p + 1 == 14)});
        else n_pass++;
      end
    end
    clear_inputs();
    tick();
    tick();
    $display("test_timeout done");
  endtask

  task automatic test_tie_round_robin();
    do_reset();
    p0_req = 1; p1_req = 1;
    tick();
    n_total++;
    if (grants !== 2'b10) $display("FAIL tie_first got=%b exp=%b", grants, 2'b10);
    else n_pass++;
    tick();
    give = 1; change = 5'd0;
    tick();
    n_total++;
    if ({p0_done, grants} !== 3'b100) $display("FAIL tie_done got=%b exp=%b", {p0_done, grants}, 3'b100);
    else n_pass++;
    give = 0;
    tick();
    n_total++;
    if (grants !== 2'b00) $display("FAIL tie_idle got=%b exp=%b", grants, 2'b00);
    else n_pass++;
    tick();
    n_total++;
    if (grants !== 2'b01) $display("FAIL rr_second got=%b exp=%b", grants, 2'b01);
    else n_pass++;
    tick();
    give = 1; change = 5'd9;
    tick();
    n_total++;
    if ({p1_done, p0_done, p1_change} !== {2'b10, 5'd9}) $display("FAIL rr_p1_done got=%b exp=%b", {p1_done, p0_done, p1_change}, {2'b10, 5'd9});
    else n_pass++;
    give = 0;
    tick();
    tick();
    n_total++;
    if (grants !== 2'b10) $display("FAIL rr_third got=%b exp=%b", grants, 2'b10);
    else n_pass++;
    clear_inputs();
    give = 1; change = 5'd0;
    tick();
    give = 0;
    tick();
    tick();
    $display("test_tie_round_robin done");
  endtask

  task automatic test_reset_mid();
    p0_req = 1;
    tick();
    p0_req = 0;
    tick();
    p0_Tenrupee = 1; reset = 1;
    tick();
    n_total++;
    if (all_out !== 23'd0) $display("FAIL reset_mid got=%h exp=%h", all_out, 23'd0);
    else n_pass++;
    reset = 0; p0_Tenrupee = 0;
    tick();
    n_total++;
    if (all_out !== 23'd0) $display("FAIL reset_mid_after got=%h exp=%h", all_out, 23'd0);
    else n_pass++;
    p0_req = 1; p1_req = 1;
    tick();
    n_total++;
    if (grants !== 2'b10) $display("FAIL reset_mid_regrant got=%b exp=%b", grants, 2'b10);
    else n_pass++;
    clear_inputs();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single_sale();
    test_coin_priority();
    test_isolation();
    test_collision();
    test_spurious_give();
    test_timeout();
    test_tie_round_robin();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
